// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - FU result ports and CDB broadcast bundle for cdb_arbiter
//
// Purpose: groups the functional-unit result handshake and the registered CDB
// broadcast outputs of cdb_arbiter into one bundle.
// Ports (all flattened MSB-first: FU f / slot s sits at the highest lane for index 0):
//   fu_valid_flat   [NUM_FU]     FU result valid
//   fu_indices_flat [4*NUM_FU]   FU ROB index
//   fu_values_flat  [16*NUM_FU]  FU result value
//   fu_ready_flat   [NUM_FU]     FU FIFO can accept an entry
//   cdb_valid_flat  [4]          CDB slot valid
//   indices_flat    [16]         CDB slot ROB index
//   new_values_flat [64]         CDB slot value
//   pending         [8]          total buffered entries
// master drives FU results (producer side), slave is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_FU = 6
);
    logic [NUM_FU-1:0]    fu_valid_flat;
    logic [4*NUM_FU-1:0]  fu_indices_flat;
    logic [16*NUM_FU-1:0] fu_values_flat;
    logic [NUM_FU-1:0]    fu_ready_flat;
    logic [3:0]           cdb_valid_flat;
    logic [15:0]          indices_flat;
    logic [63:0]          new_values_flat;
    logic [7:0]           pending;

    modport master (
        output fu_valid_flat, fu_indices_flat, fu_values_flat,
        input  fu_ready_flat, cdb_valid_flat, indices_flat, new_values_flat, pending
    );

    modport slave (
        input  fu_valid_flat, fu_indices_flat, fu_values_flat,
        output fu_ready_flat, cdb_valid_flat, indices_flat, new_values_flat, pending
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU result FIFOs with 4-slot round-robin CDB broadcast
//
// Purpose: buffers completed results from NUM_FU functional units in per-FU
// FIFOs and broadcasts up to four heads per cycle on registered CDB slots,
// scanning FUs round-robin starting at rr.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - cdb_arbiter_if.slave: FU valid/index/value in, FU ready out,
//          CDB slot valid/index/value out, pending count out
module cdb_arbiter #(
    parameter int NUM_FU     = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = $clog2(NUM_FU);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // FIFO storage and pointers
    logic [3:0]       idx_mem_q [NUM_FU][FIFO_DEPTH];
    logic [3:0]       idx_mem_d [NUM_FU][FIFO_DEPTH];
    logic [15:0]      val_mem_q [NUM_FU][FIFO_DEPTH];
    logic [15:0]      val_mem_d [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q  [NUM_FU];
    logic [PTR_W-1:0] wr_ptr_d  [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_q  [NUM_FU];
    logic [PTR_W-1:0] rd_ptr_d  [NUM_FU];
    logic [CNT_W-1:0] cnt_q     [NUM_FU];
    logic [CNT_W-1:0] cnt_d     [NUM_FU];

    // Arbitration and registered CDB slots (bit/element s = slot s)
    logic [RR_W-1:0]  rr_q, rr_d;
    logic [3:0]       cdb_valid_q, cdb_valid_d;
    logic [3:0]       slot_idx_q [4];
    logic [3:0]       slot_idx_d [4];
    logic [15:0]      slot_val_q [4];
    logic [15:0]      slot_val_d [4];
    logic [7:0]       pending_q, pending_d;

    // Per-FU unpacked views of the flattened inputs
    logic [NUM_FU-1:0] fu_valid;
    logic [NUM_FU-1:0] fu_ready;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] grant;
    logic [3:0]        fu_idx [NUM_FU];
    logic [15:0]       fu_val [NUM_FU];

    always_comb begin
        fu_valid = '0;
        fu_ready = '0;
        push     = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            fu_valid[f] = bus.fu_valid_flat[NUM_FU-1-f];
            fu_idx[f]   = bus.fu_indices_flat[4*(NUM_FU-1-f) +: 4];
            fu_val[f]   = bus.fu_values_flat[16*(NUM_FU-1-f) +: 16];
            // Ready comes from the registered count only; a full FIFO that is
            // being granted this cycle still refuses the new entry.
            fu_ready[f] = cnt_q[f] < DEPTH_C;
            push[f]     = fu_valid[f] & fu_ready[f];
        end
    end

    // Round-robin scan from rr over the FIFO heads as of the start of the cycle;
    // the k-th nonempty FIFO found fills slot k, up to four slots.
    always_comb begin : arb
        int n_grant;
        int fu_sel;
        int last_fu;
        n_grant     = 0;
        fu_sel      = 0;
        last_fu     = 0;
        grant       = '0;
        cdb_valid_d = '0;
        for (int s = 0; s < 4; s++) begin
            slot_idx_d[s] = '0;
            slot_val_d[s] = '0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            fu_sel = int'(rr_q) + i;
            if (fu_sel >= NUM_FU) begin
                fu_sel = fu_sel - NUM_FU;
            end
            if ((cnt_q[RR_W'(fu_sel)] != '0) && (n_grant < 4)) begin
                grant[RR_W'(fu_sel)]       = 1'b1;
                cdb_valid_d[2'(n_grant)]   = 1'b1;
                slot_idx_d[2'(n_grant)]    = idx_mem_q[RR_W'(fu_sel)][rd_ptr_q[RR_W'(fu_sel)]];
                slot_val_d[2'(n_grant)]    = val_mem_q[RR_W'(fu_sel)][rd_ptr_q[RR_W'(fu_sel)]];
                last_fu                    = fu_sel;
                n_grant                    = n_grant + 1;
            end
        end
        rr_d = rr_q;
        if (n_grant != 0) begin
            rr_d = (last_fu == NUM_FU - 1) ? '0 : RR_W'(last_fu + 1);
        end
    end

    // FIFO bookkeeping: push and pop may both happen in one cycle.
    always_comb begin
        pending_d = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            wr_ptr_d[f] = wr_ptr_q[f];
            rd_ptr_d[f] = rd_ptr_q[f];
            cnt_d[f]    = cnt_q[f];
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                idx_mem_d[f][e] = idx_mem_q[f][e];
                val_mem_d[f][e] = val_mem_q[f][e];
            end
            if (push[f]) begin
                idx_mem_d[f][wr_ptr_q[f]] = fu_idx[f];
                val_mem_d[f][wr_ptr_q[f]] = fu_val[f];
                wr_ptr_d[f]               = wr_ptr_q[f] + PTR_ONE;
            end
            if (grant[f]) begin
                rd_ptr_d[f] = rd_ptr_q[f] + PTR_ONE;
            end
            case ({push[f], grant[f]})
                2'b10:   cnt_d[f] = cnt_q[f] + CNT_ONE;
                2'b01:   cnt_d[f] = cnt_q[f] - CNT_ONE;
                default: cnt_d[f] = cnt_q[f];
            endcase
            pending_d = pending_d + 8'(cnt_d[f]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= '0;
            cdb_valid_q <= '0;
            pending_q   <= '0;
            for (int f = 0; f < NUM_FU; f++) begin
                wr_ptr_q[f] <= '0;
                rd_ptr_q[f] <= '0;
                cnt_q[f]    <= '0;
            end
            for (int s = 0; s < 4; s++) begin
                slot_idx_q[s] <= '0;
                slot_val_q[s] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            pending_q   <= pending_d;
            for (int f = 0; f < NUM_FU; f++) begin
                wr_ptr_q[f] <= wr_ptr_d[f];
                rd_ptr_q[f] <= rd_ptr_d[f];
                cnt_q[f]    <= cnt_d[f];
            end
            for (int s = 0; s < 4; s++) begin
                slot_idx_q[s] <= slot_idx_d[s];
                slot_val_q[s] <= slot_val_d[s];
            end
        end
    end

    // Storage needs no reset: entries are only ever read while count says valid.
    always_ff @(posedge clk) begin
        idx_mem_q <= idx_mem_d;
        val_mem_q <= val_mem_d;
    end

    always_comb begin
        bus.fu_ready_flat   = '0;
        bus.cdb_valid_flat  = '0;
        bus.indices_flat    = '0;
        bus.new_values_flat = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            bus.fu_ready_flat[NUM_FU-1-f] = fu_ready[f];
        end
        for (int s = 0; s < 4; s++) begin
            bus.cdb_valid_flat[3-s]             = cdb_valid_q[s];
            bus.indices_flat[4*(3-s) +: 4]      = slot_idx_q[s];
            bus.new_values_flat[16*(3-s) +: 16] = slot_val_q[s];
        end
        bus.pending = pending_q;
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    localparam int NUM_FU     = 6;
    localparam int FIFO_DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(NUM_FU)) bus ();

    cdb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one queue per FU, a plain integer round-robin start.
    logic [3:0]        mq_idx [NUM_FU][$];
    logic [15:0]       mq_val [NUM_FU][$];
    int                m_rr;
    logic [3:0]        e_valid;
    logic [15:0]       e_idx;
    logic [63:0]       e_val;
    logic [7:0]        e_pending;
    logic [NUM_FU-1:0] e_ready;
    int                acc_total;
    int                bc_total;

    typedef struct {
        logic        r;
        logic [5:0]  v;
        logic [23:0] ix;
        logic [95:0] vl;
        logic [3:0]  x_valid;
        logic [15:0] x_idx;
        logic [63:0] x_val;
        logic [7:0]  x_pend;
        logic [5:0]  x_ready;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [NUM_FU-1:0] v,
                              input logic [4*NUM_FU-1:0] ix, input logic [16*NUM_FU-1:0] vl);
        logic [NUM_FU-1:0] acc;
        logic [3:0]        s_idx [$];
        logic [15:0]       s_val [$];
        int                start;
        int                f;
        acc = '0;
        e_valid = '0;
        e_idx = '0;
        e_val = '0;
        if (r) begin
            for (int k = 0; k < NUM_FU; k++) begin
                mq_idx[k].delete();
                mq_val[k].delete();
            end
            m_rr = 0;
        end else begin
            for (int k = 0; k < NUM_FU; k++)
                acc[k] = v[NUM_FU-1-k] && (mq_idx[k].size() < FIFO_DEPTH);
            start = m_rr;
            for (int i = 0; i < NUM_FU; i++) begin
                f = (start + i) % NUM_FU;
                if (s_idx.size() < 4 && mq_idx[f].size() > 0) begin
                    s_idx.push_back(mq_idx[f].pop_front());
                    s_val.push_back(mq_val[f].pop_front());
                    m_rr = (f + 1) % NUM_FU;
                end
            end
            for (int s = 0; s < 4; s++) begin
                if (s < s_idx.size()) begin
                    e_valid[3-s]           = 1'b1;
                    e_idx[4*(3-s) +: 4]    = s_idx[s];
                    e_val[16*(3-s) +: 16]  = s_val[s];
                end
            end
            for (int k = 0; k < NUM_FU; k++) begin
                if (acc[k]) begin
                    mq_idx[k].push_back(ix[4*(NUM_FU-1-k) +: 4]);
                    mq_val[k].push_back(vl[16*(NUM_FU-1-k) +: 16]);
                    acc_total++;
                end
            end
        end
        e_pending = '0;
        e_ready = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            e_pending = e_pending + 8'(mq_idx[k].size());
            e_ready[NUM_FU-1-k] = (mq_idx[k].size() < FIFO_DEPTH);
        end
    endtask

    task automatic step(input logic r, input logic [NUM_FU-1:0] v,
                        input logic [4*NUM_FU-1:0] ix, input logic [16*NUM_FU-1:0] vl);
        rst = r;
        bus.fu_valid_flat = v;
        bus.fu_indices_flat = ix;
        bus.fu_values_flat = vl;
        model_edge(r, v, ix, vl);
        @(posedge clk);
        #1;
        bc_total += $countones(bus.cdb_valid_flat);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".valid"},   64'(bus.cdb_valid_flat),  64'(e_valid));
        check({tag, ".indices"}, 64'(bus.indices_flat),    64'(e_idx));
        check({tag, ".values"},  bus.new_values_flat,      e_val);
        check({tag, ".pending"}, 64'(bus.pending),         64'(e_pending));
        check({tag, ".ready"},   64'(bus.fu_ready_flat),   64'(e_ready));
    endtask

    initial begin
        logic [5:0]  bp_ready [8];
        logic [7:0]  bp_pend [8];
        int          seq [NUM_FU];
        logic [5:0]  v;
        logic [23:0] ix;
        logic [95:0] vl;
        int          max_pend;
        logic        ready_dropped;
        int          load;

        rst = 1'b1;
        bus.fu_valid_flat = '0;
        bus.fu_indices_flat = '0;
        bus.fu_values_flat = '0;
        e_ready = '1;
        m_rr = 0;
        acc_total = 0;
        bc_total = 0;

        // reset with all valid, single-result latency, round-robin over-subscription
        tbl[0]  = '{1'b1, 6'h3F, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[1]  = '{1'b1, 6'h3F, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[2]  = '{1'b0, 6'h00, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[3]  = '{1'b0, 6'h00, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[4]  = '{1'b0, 6'b001000, 24'h005000, 96'h0000_0000_00AB_0000_0000_0000,
                    4'h0, 16'h0, 64'h0, 8'd1, 6'h3F};
        tbl[5]  = '{1'b0, 6'h00, 24'h0, 96'h0, 4'b1000, 16'h5000, 64'h00AB_0000_0000_0000, 8'd0, 6'h3F};
        tbl[6]  = '{1'b0, 6'h00, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[7]  = '{1'b1, 6'h00, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};
        tbl[8]  = '{1'b0, 6'h3F, 24'h012345, 96'h0100_0101_0102_0103_0104_0105,
                    4'h0, 16'h0, 64'h0, 8'd6, 6'h3F};
        tbl[9]  = '{1'b0, 6'h00, 24'h0, 96'h0, 4'b1111, 16'h0123, 64'h0100_0101_0102_0103, 8'd2, 6'h3F};
        tbl[10] = '{1'b0, 6'h00, 24'h0, 96'h0, 4'b1100, 16'h4500, 64'h0104_0105_0000_0000, 8'd0, 6'h3F};
        tbl[11] = '{1'b0, 6'h00, 24'h0, 96'h0, 4'h0, 16'h0, 64'h0, 8'd0, 6'h3F};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].ix, tbl[i].vl);
            check($sformatf("tbl%0d.valid", i),   64'(bus.cdb_valid_flat), 64'(tbl[i].x_valid));
            check($sformatf("tbl%0d.indices", i), 64'(bus.indices_flat),   64'(tbl[i].x_idx));
            check($sformatf("tbl%0d.values", i),  bus.new_values_flat,     tbl[i].x_val);
            check($sformatf("tbl%0d.pending", i), 64'(bus.pending),        64'(tbl[i].x_pend));
            check($sformatf("tbl%0d.ready", i),   64'(bus.fu_ready_flat),  64'(tbl[i].x_ready));
        end

        // Backpressure: every FU offers every cycle; FU0 becomes full while granted.
        bp_ready = '{6'h3F, 6'h3C, 6'h33, 6'h0F, 6'h3C, 6'h33, 6'h0F, 6'h3C};
        bp_pend  = '{8'd6, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8, 8'd8};
        step(1'b1, '0, '0, '0);
        acc_total = 0;
        bc_total = 0;
        max_pend = 0;
        ready_dropped = 1'b0;
        for (int k = 0; k < NUM_FU; k++) seq[k] = 0;
        for (int c = 0; c < 8; c++) begin
            v = '1;
            ix = '0;
            vl = '0;
            for (int k = 0; k < NUM_FU; k++) begin
                ix[4*(NUM_FU-1-k) +: 4]   = 4'((k + seq[k]) & 15);
                vl[16*(NUM_FU-1-k) +: 16] = {4'(k), 12'(seq[k])};
            end
            for (int k = 0; k < NUM_FU; k++)
                if (e_ready[NUM_FU-1-k]) seq[k]++;
            step(1'b0, v, ix, vl);
            check_model($sformatf("bp%0d", c));
            check($sformatf("bp%0d.ready_hand", c), 64'(bus.fu_ready_flat), 64'(bp_ready[c]));
            check($sformatf("bp%0d.pending_hand", c), 64'(bus.pending), 64'(bp_pend[c]));
            if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);
            if (c < 4 && bus.fu_ready_flat != 6'h3F) ready_dropped = 1'b1;
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, '0, '0, '0);
            check_model($sformatf("bp_drain%0d", c));
        end
        check("bp.accepted_vs_broadcast", 64'(bc_total), 64'(acc_total));
        check("bp.max_pending_le_12", 64'(max_pend <= NUM_FU * FIFO_DEPTH), 64'd1);
        check("bp.ready_dropped_by_4", 64'(ready_dropped), 64'd1);

        // Reset mid-burst with 7 entries buffered
        step(1'b1, '0, '0, '0);
        step(1'b0, 6'h3F, 24'hEEEEEE, {6{16'hEEEE}});
        step(1'b0, 6'b111110, 24'hEEEEEE, {6{16'hEEEE}});
        check("midrst.pending_before", 64'(bus.pending), 64'd7);
        step(1'b1, '0, '0, '0);
        check("midrst.valid", 64'(bus.cdb_valid_flat), 64'd0);
        check("midrst.pending", 64'(bus.pending), 64'd0);
        check("midrst.ready", 64'(bus.fu_ready_flat), 64'h3F);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, '0, '0, '0);
            check($sformatf("midrst_idle%0d.valid", c), 64'(bus.cdb_valid_flat), 64'd0);
            check_model($sformatf("midrst_idle%0d", c));
        end

        // Randomised traffic; an FU that is refused keeps its result stable.
        v = '0;
        ix = '0;
        vl = '0;
        for (int c = 0; c < 600; c++) begin
            load = (c < 200) ? 30 : ((c < 400) ? 70 : 100);
            for (int k = 0; k < NUM_FU; k++) begin
                if (!(v[NUM_FU-1-k] && !e_ready[NUM_FU-1-k])) begin
                    v[NUM_FU-1-k]             = ($urandom_range(0, 99) < load);
                    ix[4*(NUM_FU-1-k) +: 4]   = 4'($urandom);
                    vl[16*(NUM_FU-1-k) +: 16] = 16'($urandom);
                end
            end
            step(($urandom_range(0, 79) == 0), v, ix, vl);
            if (rst) v = '0;
            check_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Transmitter side of the common data bus (CDB) into the reorder buffer.
- Accepts completed results (ROB index + 16-bit value) from NUM_FU functional-unit result ports and buffers them in per-FU FIFOs.
- Each cycle it broadcasts up to 4 results on registered, flattened CDB outputs, using round-robin arbitration.
- Downstream consumers are the ROB and the reservation stations.

Parameters:
- NUM_FU, 6, number of functional-unit result ports (2..8).
- FIFO_DEPTH, 2, entries per per-FU result FIFO (power of 2, at least 2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- fu_valid_flat  input  NUM_FU  result valid per FU; FU f at bit NUM_FU-1-f.
- fu_indices_flat  input  4*NUM_FU  ROB index per FU; FU f at bits [4*(NUM_FU-f)-1 : 4*(NUM_FU-f-1)].
- fu_values_flat  input  16*NUM_FU  result value per FU; same MSB-first ordering as fu_indices_flat.
- fu_ready_flat  output  NUM_FU  FIFO of FU f can accept an entry; FU f at bit NUM_FU-1-f.
- cdb_valid_flat  output  4  slot valid; slot s at bit 3-s.
- indices_flat  output  16  slot ROB index; slot s at bits [4*(3-s)+3 : 4*(3-s)].
- new_values_flat  output  64  slot value; slot s at bits [16*(3-s)+15 : 16*(3-s)].
- pending  output  8  total entries currently buffered across all FIFOs.

Behaviour:
- Handshake: an FU result is accepted at a posedge when its fu_valid and fu_ready are both 1. Valid with ready=0 means the FU holds index and value stable.
- fu_ready[f] = (count[f] < FIFO_DEPTH), computed from registered count only. There is no same-cycle dequeue bypass, so a full FIFO shows ready=0 even if it is granted that cycle.
- Each FIFO may enqueue and dequeue in the same cycle; count updates by +1, 0 or -1 accordingly.
- Arbitration is combinational on FIFO heads as of the start of the cycle:
  - Scan FUs rr, rr+1, … mod NUM_FU.
  - The first min(4, nonempty) nonempty FIFOs are granted, at most one grant per FU per cycle.
  - Grant k fills slot k, lowest slots first.
- Granted heads pop at the posedge. The CDB registers load at the same posedge:
  - slot valid=1 with that FU's head index/value;
  - unused slots have valid=0, index=0, value=0.
- Latency: a result accepted at edge k is, at earliest, visible on the CDB after edge k+1. It is never visible in the same cycle it is accepted.
- Round-robin pointer: rr <= (last granted FU + 1) mod NUM_FU. rr is unchanged when there are no grants. rr width is ceil(log2(NUM_FU)).
- CDB outputs are single-cycle pulses. If there are no grants, the next cycle has cdb_valid_flat=0.
- Each FU's results appear on the CDB in acceptance order. No result is dropped or duplicated.
- No checking of index uniqueness; duplicate ROB indices are passed through as given.
- pending = sum of counts, updated at each posedge.
- Reset, including mid-operation:
  - all FIFOs emptied (buffered results discarded);
  - rr=0, pending=0;
  - cdb_valid_flat=0, indices_flat=0, new_values_flat=0;
  - fu_ready_flat all 1 on the cycle after reset.
- rst has priority over simultaneous enqueue and grant. Nothing is accepted on a reset edge.
- FIFO pointers wrap mod FIFO_DEPTH. Full and empty are derived from count, not from pointer equality.

Test Plan:
- Reset:
  - Stimulus: assert rst for 2 cycles with all fu_valid=1.
  - Response: cdb_valid_flat=0000, pending=0, fu_ready_flat=111111 after release; nothing is broadcast later.
- Single result latency:
  - Stimulus: FU2 pushes index=5, value=0x00AB at edge 1, nothing else active.
  - Response: after edge 2, cdb_valid_flat=1000, indices_flat=0x5000, slot0 value=0x00AB; after edge 3, cdb_valid_flat=0000.
- Round-robin over-subscription:
  - Stimulus: all 6 FUs push one result each (FU f: index=f, value=0x100+f) in the same cycle, rr=0.
  - Response, next cycle: slots carry FUs 0,1,2,3, rr=4.
  - Response, following cycle: slots 0,1 carry FUs 4,5 with cdb_valid_flat=1100, rr=0.
- Backpressure:
  - Stimulus: all 6 FUs assert valid every cycle for 8 cycles with unique indices.
  - Response: some fu_ready bit deasserts by cycle 4; the scoreboard shows accepted count = broadcast count; per-FU order is preserved; pending never exceeds 12.
- Simultaneous enqueue/dequeue on a full FIFO:
  - Stimulus: FU0 FIFO full and granted while fu_valid[0]=1.
  - Response: fu_ready[0]=0, so the new result is not accepted that cycle; the next cycle ready=1 and the entry is accepted; count goes 2→1→2.
- Reset mid-burst:
  - Stimulus: pending=7, then assert rst for 1 cycle.
  - Response: following cycle cdb_valid_flat=0000, pending=0; the old buffered indices never appear on the CDB.
